// File: rtl/if_stage_pkg.sv
// Shared constants and FSM encoding for the instruction-fetch stage.
package if_stage_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSN         = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_STEP          = 32'd4;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/if_stage_ifid.sv
// IF/ID pipeline register: load, hold or flush to a bubble; reset also yields a bubble.
module ifid_reg
    import if_stage_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            flush,
    input  logic [XLEN-1:0] insn_in,
    input  logic [XLEN-1:0] pc_in,
    output logic [XLEN-1:0] insn,
    output logic [XLEN-1:0] pc,
    output logic            valid
);

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            insn  <= NOP_INSN;
            pc    <= '0;
            valid <= 1'b0;
        end else if (load) begin
            insn  <= insn_in;
            pc    <= pc_in;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: owns the PC, drives a req/ready instruction port and feeds IF/ID.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            IFWrite,
    input  logic            Branch,
    input  logic            Jump,
    input  logic [XLEN-1:0] JumpAddr,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] PC_if,
    output logic [XLEN-1:0] Instruction_id,
    output logic [XLEN-1:0] PC_id,
    output logic            ifid_valid
);

    fetch_state_e    state, state_next;
    logic [XLEN-1:0] pc, pc_next;
    logic [XLEN-1:0] target, target_next;
    logic [XLEN-1:0] buf_insn, buf_pc;
    logic            buf_load;
    logic            ifid_load, ifid_flush;
    logic [XLEN-1:0] ifid_insn_in, ifid_pc_in;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            unused_jump_lsbs;

    // A redirect during an ID stall is ignored; ID presents it again afterwards.
    assign redirect         = (Branch | Jump) & IFWrite;
    assign redirect_pc      = {JumpAddr[XLEN-1:2], 2'b00};
    assign unused_jump_lsbs = ^JumpAddr[1:0];

    assign imem_req  = ~reset & (state != ST_HOLD);
    assign imem_addr = pc;
    assign PC_if     = pc;

    always_comb begin
        state_next   = state;
        pc_next      = pc;
        target_next  = target;
        buf_load     = 1'b0;
        ifid_load    = 1'b0;
        ifid_flush   = 1'b0;
        ifid_insn_in = imem_rdata;
        ifid_pc_in   = pc;
        case (state)
            ST_RUN: begin
                if (redirect) begin
                    ifid_flush = 1'b1;
                    if (imem_ready) begin
                        pc_next = redirect_pc;
                    end else begin
                        // Request already on the bus must complete at the old address.
                        target_next = redirect_pc;
                        state_next  = ST_DRAIN;
                    end
                end else if (IFWrite) begin
                    if (imem_ready) begin
                        ifid_load = 1'b1;
                        pc_next   = pc + PC_STEP;
                    end else begin
                        ifid_flush = 1'b1;
                    end
                end else if (imem_ready) begin
                    buf_load   = 1'b1;
                    pc_next    = pc + PC_STEP;
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    ifid_flush = 1'b1;
                    pc_next    = redirect_pc;
                    state_next = ST_RUN;
                end else if (IFWrite) begin
                    ifid_load    = 1'b1;
                    ifid_insn_in = buf_insn;
                    ifid_pc_in   = buf_pc;
                    state_next   = ST_RUN;
                end
            end
            ST_DRAIN: begin
                ifid_flush = IFWrite;
                if (redirect) begin
                    target_next = redirect_pc;
                end
                // The stale response is dropped; fetch resumes at the newest target.
                if (imem_ready) begin
                    pc_next    = target_next;
                    state_next = ST_RUN;
                end
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_RUN;
            pc    <= RESET_PC;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    // Skid buffer and redirect target carry data only; FSM state qualifies them.
    always_ff @(posedge clk) begin
        target <= target_next;
        if (buf_load) begin
            buf_insn <= imem_rdata;
            buf_pc   <= pc;
        end
    end

    ifid_reg u_ifid (
        .clk     (clk),
        .reset   (reset),
        .load    (ifid_load),
        .flush   (ifid_flush),
        .insn_in (ifid_insn_in),
        .pc_in   (ifid_pc_in),
        .insn    (Instruction_id),
        .pc      (PC_id),
        .valid   (ifid_valid)
    );

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios, then randomized stall/redirect/wait-state traffic.
module tb_if_stage;
    import if_stage_pkg::*;

    localparam logic [31:0] MASK = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        reset, IFWrite, Branch, Jump;
    logic [31:0] JumpAddr;
    logic        imem_req, imem_ready;
    logic [31:0] imem_addr, imem_rdata, PC_if, Instruction_id, PC_id;
    logic        ifid_valid;

    always #5 clk = ~clk;

    if_stage dut (
        .clk            (clk),
        .reset          (reset),
        .IFWrite        (IFWrite),
        .Branch         (Branch),
        .Jump           (Jump),
        .JumpAddr       (JumpAddr),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .PC_if          (PC_if),
        .Instruction_id (Instruction_id),
        .PC_id          (PC_id),
        .ifid_valid     (ifid_valid)
    );

    // Memory: fixed wait states on one address (directed) or random per request.
    logic        directed   = 1'b1;
    logic [31:0] slow_addr  = 32'h8;
    int          slow_waits = 2;
    int          cnt        = 0;
    int          rnd_waits  = 0;
    int          need;

    assign need       = directed ? ((imem_addr == slow_addr) ? slow_waits : 0) : rnd_waits;
    assign imem_ready = imem_req && (cnt >= need);
    assign imem_rdata = imem_addr ^ MASK;

    always @(posedge clk) begin
        if (reset || !imem_req || imem_ready) begin
            cnt       <= 0;
            rnd_waits <= ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
        end else begin
            cnt <= cnt + 1;
        end
    end

    // Reference model: pending skid entry, pending redirect target, IF/ID contents.
    logic [31:0] m_pc = 0, m_tgt = 0, m_skid_insn = 0, m_skid_pc = 0;
    logic [31:0] m_id_insn = NOP_INSN, m_id_pc = 0;
    logic        m_skid_v = 0, m_tgt_v = 0, m_id_v = 0;
    logic        ev_rst = 0, ev_redir = 0, ev_ifw = 0, pend = 0;
    logic [31:0] ev_t = 0, pend_addr = 0;
    logic        m_redir;
    logic [31:0] m_t;

    task automatic m_bubble();
        m_id_insn = NOP_INSN;
        m_id_pc   = 32'h0;
        m_id_v    = 1'b0;
    endtask

    always @(posedge clk) begin
        m_redir   = (Branch | Jump) & IFWrite;
        m_t       = JumpAddr & 32'hFFFF_FFFC;
        ev_rst    = reset;
        ev_redir  = !reset && m_redir;
        ev_t      = m_t;
        ev_ifw    = !reset && IFWrite;
        pend      = imem_req && !imem_ready && !reset;
        pend_addr = imem_addr;
        if (reset) begin
            m_pc     = RESET_PC_DEFAULT;
            m_skid_v = 1'b0;
            m_tgt_v  = 1'b0;
            m_bubble();
        end else if (m_skid_v) begin
            if (m_redir) begin
                m_bubble();
                m_skid_v = 1'b0;
                m_pc     = m_t;
            end else if (IFWrite) begin
                m_id_insn = m_skid_insn;
                m_id_pc   = m_skid_pc;
                m_id_v    = 1'b1;
                m_skid_v  = 1'b0;
            end
        end else if (m_tgt_v) begin
            if (IFWrite) m_bubble();
            if (m_redir) m_tgt = m_t;
            if (imem_ready) begin
                m_pc    = m_tgt;
                m_tgt_v = 1'b0;
            end
        end else if (m_redir) begin
            m_bubble();
            if (imem_ready) m_pc = m_t;
            else begin
                m_tgt   = m_t;
                m_tgt_v = 1'b1;
            end
        end else if (IFWrite) begin
            if (imem_ready) begin
                m_id_insn = m_pc ^ MASK;
                m_id_pc   = m_pc;
                m_id_v    = 1'b1;
                m_pc      = m_pc + 32'd4;
            end else begin
                m_bubble();
            end
        end else if (imem_ready) begin
            m_skid_insn = m_pc ^ MASK;
            m_skid_pc   = m_pc;
            m_skid_v    = 1'b1;
            m_pc        = m_pc + 32'd4;
        end
    end

    int          total = 0;
    int          bad   = 0;
    logic [31:0] s_exp = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison plus the program-order stream check on ID loads.
    task automatic compare_all();
        chk("imem_req", {31'b0, imem_req}, {31'b0, (!reset && !m_skid_v)});
        chk("imem_addr", imem_addr, m_pc);
        chk("PC_if", PC_if, m_pc);
        chk("Instruction_id", Instruction_id, m_id_insn);
        chk("PC_id", PC_id, m_id_pc);
        chk("ifid_valid", {31'b0, ifid_valid}, {31'b0, m_id_v});
        if (pend && imem_req) chk("addr_stable", imem_addr, pend_addr);
        if (ev_rst) s_exp = RESET_PC_DEFAULT;
        else if (ev_redir) s_exp = ev_t;
        if (ev_ifw && ifid_valid) begin
            chk("stream_pc", PC_id, s_exp);
            chk("stream_insn", Instruction_id, s_exp ^ MASK);
            s_exp = s_exp + 32'd4;
        end
    endtask

    task automatic step(input logic r, input logic w, input logic b, input logic j,
                        input logic [31:0] a);
        #1;
        reset = r; IFWrite = w; Branch = b; Jump = j; JumpAddr = a;
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        int guard;
        reset = 1'b1; IFWrite = 1'b1; Branch = 1'b0; Jump = 1'b0; JumpAddr = 32'h0;
        @(negedge clk);
        step(1, 1, 0, 0, 0);
        chk("rst_req", {31'b0, imem_req}, 32'h0);
        chk("rst_pc", PC_if, 32'h0);
        chk("rst_bubble_insn", Instruction_id, 32'h0000_0013);

        // Zero-wait fetch, then two wait states at 0x8.
        step(0, 1, 0, 0, 0);
        chk("first_insn", Instruction_id, 32'hA5A5_0000);
        chk("first_pcid", PC_id, 32'h0);
        chk("first_valid", {31'b0, ifid_valid}, 32'h1);
        chk("addr_4", imem_addr, 32'h4);
        step(0, 1, 0, 0, 0);
        chk("addr_8", imem_addr, 32'h8);
        step(0, 1, 0, 0, 0);
        chk("wait1_addr", imem_addr, 32'h8);
        chk("wait1_bubble", {31'b0, ifid_valid}, 32'h0);
        step(0, 1, 0, 0, 0);
        chk("wait2_addr", imem_addr, 32'h8);
        chk("wait2_bubble", {31'b0, ifid_valid}, 32'h0);
        step(0, 1, 0, 0, 0);
        chk("slow_pcid", PC_id, 32'h8);
        chk("slow_valid", {31'b0, ifid_valid}, 32'h1);
        chk("after_slow_addr", imem_addr, 32'hC);

        // Load-use stall while 0x2C is returned.
        guard = 0;
        while (imem_addr != 32'h2C && guard < 40) begin
            step(0, 1, 0, 0, 0);
            guard++;
        end
        chk("reach_2c", imem_addr, 32'h2C);
        step(0, 0, 0, 0, 0);
        chk("stall_pcid", PC_id, 32'h28);
        chk("stall_req", {31'b0, imem_req}, 32'h0);
        step(0, 1, 0, 0, 0);
        chk("unstall_insn", Instruction_id, 32'hA5A5_002C);
        chk("unstall_addr", imem_addr, 32'h30);

        // Jump while 0x10 is being fetched with ready.
        step(0, 1, 0, 1, 32'h10);
        chk("jmp1_addr", imem_addr, 32'h10);
        step(0, 1, 0, 1, 32'h30);
        chk("jmp2_addr", imem_addr, 32'h30);
        chk("jmp2_bubble", {31'b0, ifid_valid}, 32'h0);
        step(0, 1, 0, 0, 0);
        chk("jmp_target_pcid", PC_id, 32'h30);

        // Branch to 0x1 while 0x1C is pending.
        slow_addr = 32'h1C; slow_waits = 2;
        step(0, 1, 0, 1, 32'h1C);
        step(0, 1, 1, 0, 32'h1);
        chk("drain1_addr", imem_addr, 32'h1C);
        step(0, 1, 0, 0, 0);
        chk("drain2_addr", imem_addr, 32'h1C);
        chk("drain2_bubble", {31'b0, ifid_valid}, 32'h0);
        step(0, 1, 0, 0, 0);
        chk("drain_done_addr", imem_addr, 32'h0);
        chk("drain_done_bubble", {31'b0, ifid_valid}, 32'h0);
        step(0, 1, 0, 0, 0);
        chk("after_drain_pcid", PC_id, 32'h0);

        // Reset while draining.
        slow_addr = 32'h40; slow_waits = 3;
        step(0, 1, 0, 1, 32'h40);
        step(0, 1, 0, 1, 32'h80);
        chk("pre_rst_drain_addr", imem_addr, 32'h40);
        step(1, 1, 0, 0, 0);
        chk("rst_drain_pc", PC_if, 32'h0);
        chk("rst_drain_req", {31'b0, imem_req}, 32'h0);
        chk("rst_drain_bubble", {31'b0, ifid_valid}, 32'h0);
        step(0, 1, 0, 0, 0);
        chk("resume_pcid", PC_id, 32'h0);
        chk("resume_valid", {31'b0, ifid_valid}, 32'h1);

        // Low bits of the target are dropped and the PC wraps at 2^32.
        slow_addr = 32'h1;
        step(0, 1, 0, 1, 32'hFFFF_FFFE);
        chk("top_addr", imem_addr, 32'hFFFF_FFFC);
        step(0, 1, 0, 0, 0);
        chk("top_pcid", PC_id, 32'hFFFF_FFFC);
        chk("wrap_addr", imem_addr, 32'h0);

        directed = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] a;
            case ($urandom_range(0, 3))
                0:       a = 32'hFFFF_FFF0 | $urandom_range(0, 15);
                default: a = $urandom_range(0, 255);
            endcase
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 4) != 0),
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 11) == 0), a);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
